// File: rtl/montador_digitos_pkg.sv
// Shared types and key constants for the keypad packet assembler.
// Packets are N_DIG BCD digits; index 0 is the most recently entered digit.
package montador_digitos_pkg;

  localparam int N_DIG = 20;

  typedef logic [N_DIG-1:0][3:0] senhaPac_t;

  localparam logic [3:0] KEY_STAR  = 4'hA;
  localparam logic [3:0] KEY_HASH  = 4'hB;
  localparam logic [3:0] DIG_EMPTY = 4'hF;

  // All-'#' packet: tells downstream FSMs to keep their current value.
  localparam senhaPac_t SENHA_KEEP  = {N_DIG{KEY_HASH}};
  localparam senhaPac_t SENHA_EMPTY = {N_DIG{DIG_EMPTY}};

endpackage

// File: rtl/montador_digitos_timeout_cnt.sv
// Purpose: inactivity counter; expire fires on the TIMEOUT_CYC-th consecutive inc cycle.
// Latency: expire is combinational from the registered count; clr/expire zero it next edge.
// Backpressure: none; clr has priority over inc.
module montador_digitos_timeout_cnt #(
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_CYC);

  logic [W-1:0] cnt;

  assign expire = inc && (cnt == W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || expire) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/montador_digitos.sv
// Purpose: assemble keypad digits into a senhaPac_t packet, emitted on '#'.
// Latency: one cycle from key strobe to buffer/packet update; digitos_valid pulses 1 cycle.
// Backpressure: none; keys are accepted every cycle, digits beyond N_DIG are dropped.
module montador_digitos
  import montador_digitos_pkg::*;
#(
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output senhaPac_t  digitos_value,
  output logic       digitos_valid,
  output senhaPac_t  buffer_live,
  output logic [4:0] digit_count
);

  typedef enum logic {IDLE, COLETA} state_t;

  state_t state;
  logic   is_digit, is_star, is_hash, key_act, cnt_run, expire;

  assign is_digit = (key_code <= 4'd9);
  assign is_star  = (key_code == KEY_STAR);
  assign is_hash  = (key_code == KEY_HASH);
  // Codes C-F are not keys at all: they neither clear nor pause the idle timer.
  assign key_act  = key_valid && en && (state == COLETA) && (is_digit || is_star || is_hash);
  assign cnt_run  = (state == COLETA) && en && (digit_count != 5'd0) && !key_act;

  montador_digitos_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (!cnt_run),
    .inc    (cnt_run),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      digitos_value <= SENHA_EMPTY;
      digitos_valid <= 1'b0;
      buffer_live   <= SENHA_EMPTY;
      digit_count   <= 5'd0;
    end else begin
      digitos_valid <= 1'b0;
      case (state)
        IDLE: begin
          buffer_live <= SENHA_EMPTY;
          digit_count <= 5'd0;
          if (en) state <= COLETA;
        end
        COLETA: begin
          if (!en) begin
            state       <= IDLE;
            buffer_live <= SENHA_EMPTY;
            digit_count <= 5'd0;
          end else if (key_act) begin
            if (is_digit) begin
              if (digit_count < 5'(N_DIG)) begin
                buffer_live <= {buffer_live[N_DIG-2:0], key_code};
                digit_count <= digit_count + 5'd1;
              end
            end else begin
              if (is_hash) begin
                digitos_value <= (digit_count == 5'd0) ? SENHA_KEEP : buffer_live;
                digitos_valid <= 1'b1;
              end
              buffer_live <= SENHA_EMPTY;
              digit_count <= 5'd0;
            end
          end else if (expire) begin
            buffer_live <= SENHA_EMPTY;
            digit_count <= 5'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_montador_digitos.sv
// Bench for montador_digitos: entry-order digit list model checked every cycle,
// plus directed scenarios pinned with hand-computed packet literals.
module tb_montador_digitos;

  localparam int T = 24;

  logic        clk, rst, en, key_valid;
  logic [3:0]  key_code;
  logic [79:0] digitos_value, buffer_live;
  logic        digitos_valid;
  logic [4:0]  digit_count;

  montador_digitos #(.TIMEOUT_CYC(T)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .key_code      (key_code),
    .key_valid     (key_valid),
    .digitos_value (digitos_value),
    .digitos_valid (digitos_valid),
    .buffer_live   (buffer_live),
    .digit_count   (digit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;

  localparam logic [79:0] ALL_F = {20{4'hF}};
  localparam logic [79:0] ALL_B = {20{4'hB}};

  // Model: digits kept in entry order, idle cycles counted since the last key.
  bit          collecting;
  logic [3:0]  q[$];
  int          idle;
  logic [79:0] m_val;
  bit          m_vld;

  function automatic logic [79:0] packed_q();
    logic [79:0] r;
    for (int i = 0; i < 20; i++)
      r[i*4 +: 4] = (i < q.size()) ? q[q.size()-1-i] : 4'hF;
    return r;
  endfunction

  task automatic model_reset();
    collecting = 0; q.delete(); idle = 0; m_val = ALL_F; m_vld = 0;
  endtask

  task automatic model_step(input logic e, input logic v, input logic [3:0] c);
    m_vld = 0;
    if (!collecting) begin
      q.delete(); idle = 0;
      if (e) collecting = 1;
    end else if (!e) begin
      collecting = 0; q.delete(); idle = 0;
    end else if (v && c <= 4'd9) begin
      if (q.size() < 20) q.push_back(c);
      idle = 0;
    end else if (v && c == 4'hA) begin
      q.delete(); idle = 0;
    end else if (v && c == 4'hB) begin
      m_val = (q.size() == 0) ? ALL_B : packed_q();
      m_vld = 1; q.delete(); idle = 0;
    end else if (q.size() > 0) begin
      idle++;
      if (idle == T) begin q.delete(); idle = 0; end
    end
  endtask

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", 80'(digitos_valid), 80'(m_vld));
      chk("value", digitos_value, m_val);
      chk("live", buffer_live, packed_q());
      chk("count", 80'(digit_count), 80'(q.size()));
    end
  end

  task automatic step(input logic e, input logic v, input logic [3:0] c);
    en = e; key_valid = v; key_code = c;
    @(posedge clk);
    model_step(e, v, c);
    @(negedge clk);
  endtask

  task automatic key(input logic [3:0] c);
    step(1'b1, 1'b1, c);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'h0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_val"}, digitos_value, ALL_F);
    chk({tag, "_live"}, buffer_live, ALL_F);
    chk({tag, "_vld"}, 80'(digitos_valid), 80'd0);
    chk({tag, "_cnt"}, 80'(digit_count), 80'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; key_valid = 1'b0; key_code = 4'h0;
    model_reset();
    #12;
    check_reset_vals("rst0");
    @(negedge clk); rst = 1'b0; chk_en = 1;

    step(1'b1, 1'b0, 4'h0);
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    chk("live_1234", buffer_live, 80'hFFFF_FFFF_FFFF_FFFF_1234);
    key(4'hB);
    chk("pkt_1234", digitos_value, 80'hFFFF_FFFF_FFFF_FFFF_1234);
    chk("pulse_1234", 80'(digitos_valid), 80'd1);
    chk("cnt_after_hash", 80'(digit_count), 80'd0);
    idle_n(1);
    chk("pulse_end", 80'(digitos_valid), 80'd0);

    key(4'hB);
    chk("keep_1", digitos_value, ALL_B);
    key(4'hB);
    chk("keep_2", digitos_value, ALL_B);
    chk("keep_2_vld", 80'(digitos_valid), 80'd1);

    key(4'd5); key(4'd7); key(4'hA);
    chk("star_nopulse", 80'(digitos_valid), 80'd0);
    key(4'd9); key(4'hB);
    chk("pkt_9", digitos_value, 80'hFFFF_FFFF_FFFF_FFFF_FFF9);

    for (int i = 0; i < 22; i++) key(4'(i % 10));
    chk("sat_cnt", 80'(digit_count), 80'd20);
    key(4'hB);
    chk("pkt_sat", digitos_value, 80'h0123_4567_8901_2345_6789);

    key(4'd1); key(4'd2); idle_n(T);
    chk("tmo_live", buffer_live, ALL_F);
    chk("tmo_cnt", 80'(digit_count), 80'd0);
    key(4'd1); key(4'd2); idle_n(T - 1); key(4'd7);
    chk("tmo_race_live", buffer_live, 80'hFFFF_FFFF_FFFF_FFFF_F127);
    chk("tmo_race_cnt", 80'(digit_count), 80'd3);
    key(4'hA);

    key(4'd3); key(4'd4); step(1'b0, 1'b1, 4'd5);
    chk("en_off_live", buffer_live, ALL_F);
    chk("en_off_vld", 80'(digitos_valid), 80'd0);
    step(1'b1, 1'b0, 4'h0);

    for (int blk = 0; blk < 40; blk++) begin
      int pkey = (blk % 3 == 2) ? 3 : 50;
      for (int i = 0; i < 80; i++) begin
        logic e, v;
        logic [3:0] c;
        int r = $urandom_range(0, 99);
        e = ($urandom_range(0, 99) < 98) ? en : ~en;
        v = ($urandom_range(0, 99) < pkey);
        if (r < 70)      c = 4'($urandom_range(0, 9));
        else if (r < 85) c = 4'hB;
        else if (r < 92) c = 4'hA;
        else             c = 4'($urandom_range(12, 15));
        step(e, v, c);
      end
    end

    en = 1'b1; step(1'b1, 1'b0, 4'h0);
    key(4'd3); key(4'd4);
    chk_en = 0;
    #2 rst = 1'b1;
    #1 check_reset_vals("async_rst");
    model_reset();
    @(negedge clk); rst = 1'b0; chk_en = 1;
    step(1'b1, 1'b0, 4'h0);
    key(4'd8); key(4'hB);
    chk("post_rst_pkt", digitos_value, 80'hFFFF_FFFF_FFFF_FFFF_FFF8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/montador_digitos.md
Name: montador_digitos

Overview:
Keypad-to-packet assembler sitting directly upstream of the lock's setup and operation FSMs. Collects decoded key strobes into a 20-digit BCD buffer. On '#' it emits one senhaPac_t packet with a single-cycle digitos_valid pulse. Also provides a live view of the buffer for display echo, plus an inactivity timeout that discards partial entries.

Parameters:
N_DIG, 20, buffer depth in digits; must match senhaPac_t.
TIMEOUT_CYC, 5000, idle cycles after the last key before a partial entry is discarded (5 s at 1 kHz).

Ports:
clk  input  1  clock.
rst  input  1  reset, asynchronous, active-high.
en  input  1  collection enable; low = ignore keys and hold buffer empty.
key_code  input  4  decoded key: 0-9 digit, 4'hA '*', 4'hB '#', others ignored.
key_valid  input  1  one-cycle strobe, key_code qualified.
digitos_value  output  80 (senhaPac_t)  last emitted packet; index 0 = most recent digit.
digitos_valid  output  1  one-cycle pulse, packet valid.
buffer_live  output  80 (senhaPac_t)  current in-progress buffer, for display.
digit_count  output  5  number of digits in buffer, 0..20.

Behaviour:
- Reset (async, any state):
  - digitos_value = all 4'hF; buffer_live = all 4'hF.
  - digitos_valid = 0; digit_count = 0.
  - timeout counter = 0; state = IDLE.
- Empty slots always hold 4'hF.
- Digit key (0-9) in COLETA with count < 20:
  - buffer[i] <= buffer[i-1] for i = 19..1; buffer[0] <= key; count++; timeout counter cleared.
  - Entering 1,2,3,4 yields {16x F, 1, 2, 3, 4}.
- Digit key with count = 20: dropped, buffer unchanged; timeout counter still cleared.
- '*' (4'hA): buffer <= all F, count <= 0, no emission.
- '#' (4'hB) at cycle N:
  - Non-empty buffer: digitos_value <= buffer, digitos_valid = 1 during cycle N+1 only.
  - Empty buffer (count = 0): digitos_value <= all 4'hB ("keep current value" token), with the same pulse.
  - Buffer cleared and count <= 0 at the same edge.
  - digitos_value holds until the next emission.
- Codes 4'hC-4'hF: ignored, no effect on the timeout counter.
- Key handling in the cycle after '#' is normal; the buffer is already empty. Back-to-back '#' produces two pulses, the second being the all-B token.
- FSM:
  - IDLE: en = 0. Buffer held all F, keys ignored. en rising -> COLETA.
  - COLETA: keys processed as above.
    - count > 0: timeout counter increments each cycle without a valid key. Reaching TIMEOUT_CYC-1 -> buffer cleared, count 0, no emission, stay in COLETA.
    - en falling -> IDLE; buffer cleared, no emission. A key strobe in the same cycle as en = 0 is ignored.
- Simultaneous key_valid and timeout expiry: the key wins. The timeout is cancelled and the key is processed against the existing buffer.
- Timeout counter is idle (held 0) while count = 0.
- Width rules:
  - Timeout counter width = $clog2(TIMEOUT_CYC).
  - digit_count saturates at 20.

Decomposition:
- Shared package (Tipos.sv):
  - senhaPac_t.
  - Key code constants: KEY_STAR = 4'hA, KEY_HASH = 4'hB, DIG_EMPTY = 4'hF.
  - Token constant SENHA_KEEP = all 4'hB.
  - FSM enum local to the module.
- One natural sub-module: timeout_cnt (clear/enable/expire counter parameterised by TIMEOUT_CYC). Everything else stays flat.

Test Plan:
- Reset, en = 1, keys 1,2,3,4,'#' -> one cycle after '#', digitos_valid = 1 for exactly one cycle, digitos_value = {16x F,1,2,3,4}, digit_count back to 0.
- en = 1, '#' on empty buffer -> digitos_value = 20x 4'hB with a single pulse. A second '#' the next cycle -> second pulse, same value.
- Keys 5,7,'*',9,'#' -> digitos_value = {19x F, 9}. No pulse on '*'.
- 22 digits 0..9 repeating, then '#' -> only the first 20 retained. digitos_value[0] = 9 (20th key), [19] = 0. digit_count peaks at 20.
- Keys 1,2 then idle TIMEOUT_CYC cycles -> buffer_live all F, count 0, no pulse. Repeat with a digit strobe exactly at the expiry cycle -> buffer = {..,1,2,d}, count 3.
- Keys 3,4 then en = 0 -> IDLE, buffer cleared, no pulse. Assert rst mid-entry -> all outputs at reset values asynchronously.
